// File: rtl/pkt_translator_pkg.sv
// Shared types and helpers for the 32-to-64 bit store-and-forward packet translator.
package pkt_translator_pkg;
    localparam int LEN_W  = 14;
    localparam int BEAT_W = 11;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [BEAT_W-1:0] beats;
        logic              half;
    } desc_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } rd_state_e;

    // Byte length from the number of words before the EOP word and the EOP residual.
    function automatic logic [LEN_W-1:0] pkt_len(input logic [LEN_W-3:0] prev_words,
                                                 input logic [1:0]       res);
        return {prev_words, 2'b00} + ((res == 2'd0) ? LEN_W'(4) : LEN_W'(res));
    endfunction
endpackage

// File: rtl/pkt_buf_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port.
module pkt_buf_ram #(
    parameter int DEPTH = 2048,
    parameter int WIDTH = 64
) (
    input  logic                     iclk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_re,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Read data holds while i_re is low so a stalled beat stays available.
    always_ff @(posedge iclk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/pkt_translator.sv
// Store-and-forward 32-to-64 bit packet converter; whole packets are buffered so the
// SOP beat carries the byte length, and bad packets are dropped before reaching the output.
module pkt_translator
    import pkt_translator_pkg::*;
#(
    parameter int INPUT_WIDTH  = 32,
    parameter int OUTPUT_WIDTH = 64,
    parameter int BUF_DEPTH    = 2048,
    parameter int DESC_DEPTH   = 16
) (
    input  logic                    iclk,
    input  logic                    irst_n,
    input  logic                    ivalid,
    input  logic                    isop,
    input  logic                    ieop,
    input  logic [1:0]              iresidual,
    input  logic [INPUT_WIDTH-1:0]  idata,
    input  logic                    ibad,
    output logic                    ovalid,
    output logic                    ohalf_word_valid,
    output logic                    osop,
    output logic                    oeop,
    output logic [LEN_W-1:0]        oplen,
    output logic [OUTPUT_WIDTH-1:0] odata,
    output logic                    obad,
    input  logic                    oready,
    output logic                    ocpu_interrupt
);
    localparam int AW     = $clog2(BUF_DEPTH);
    localparam int DW     = $clog2(DESC_DEPTH);
    localparam int WCNT_W = LEN_W - 2;

    logic                    r_open, r_odd, r_bad, r_ovf, r_irq;
    logic [INPUT_WIDTH-1:0]  r_pair;
    logic [WCNT_W-1:0]       r_wcnt;
    logic [BEAT_W-1:0]       r_bcnt;
    logic [AW-1:0]           r_wptr, r_cptr, r_rptr;
    logic                    w_acc, w_odd, w_wr, w_full, w_we, w_bad, w_ovf, w_eop, w_push, w_drop;
    logic [AW-1:0]           w_base;
    logic [WCNT_W-1:0]       w_wcnt;
    logic [BEAT_W-1:0]       w_bcnt;
    logic [OUTPUT_WIDTH-1:0] w_wdata, w_rdata;
    desc_t                   w_desc, w_desc_rd;

    // An isop always restarts at the committed pointer, discarding any open packet.
    assign w_acc   = ivalid && (isop || r_open);
    assign w_base  = isop ? r_cptr : r_wptr;
    assign w_odd   = !isop && r_odd;
    assign w_wcnt  = isop ? '0 : r_wcnt;
    assign w_bcnt  = isop ? '0 : r_bcnt;
    assign w_wr    = w_acc && (w_odd || ieop);
    assign w_full  = (w_base + AW'(1)) == r_rptr;
    assign w_we    = w_wr && !w_full;
    assign w_bad   = (!isop && r_bad) || ibad;
    assign w_ovf   = (!isop && r_ovf) || (w_wr && w_full);
    assign w_wdata = w_odd ? {r_pair, idata} : {idata, {INPUT_WIDTH{1'b0}}};
    assign w_eop   = w_acc && ieop;

    logic                    w_dfull, w_dempty, w_pop;
    desc_t                   r_dmem [DESC_DEPTH];
    logic [DW-1:0]           r_dwp, r_drp;
    logic [DW:0]             r_dcnt;

    assign w_push       = w_eop && !w_bad && !w_ovf && !w_dfull;
    assign w_drop       = (w_eop && !w_push) || (ivalid && isop && r_open);
    assign w_desc.len   = pkt_len(w_wcnt, iresidual);
    assign w_desc.beats = w_bcnt + BEAT_W'(1);
    assign w_desc.half  = !w_odd;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_open <= 1'b0;
            r_odd  <= 1'b0;
            r_bad  <= 1'b0;
            r_ovf  <= 1'b0;
            r_irq  <= 1'b0;
            r_pair <= '0;
            r_wcnt <= '0;
            r_bcnt <= '0;
            r_wptr <= '0;
            r_cptr <= '0;
        end else begin
            r_irq <= w_drop;
            if (w_acc) begin
                r_open <= !ieop;
                r_odd  <= !w_odd;
                r_wcnt <= w_wcnt + WCNT_W'(1);
                r_bcnt <= w_bcnt + BEAT_W'(w_wr);
                r_bad  <= w_bad;
                r_ovf  <= w_ovf;
                if (!w_odd) r_pair <= idata;
            end
            if (w_push) begin
                r_wptr <= w_base + AW'(1);
                r_cptr <= w_base + AW'(1);
            end else if (w_eop) begin
                r_wptr <= r_cptr;
            end else if (w_acc) begin
                r_wptr <= w_base + AW'(w_we);
            end
        end
    end

    assign w_dfull   = (r_dcnt == (DW+1)'(DESC_DEPTH));
    assign w_dempty  = (r_dcnt == '0);
    assign w_desc_rd = r_dmem[r_drp];

    always_ff @(posedge iclk) begin
        if (w_push) r_dmem[r_dwp] <= w_desc;
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_dwp  <= '0;
            r_drp  <= '0;
            r_dcnt <= '0;
        end else begin
            if (w_push) r_dwp <= r_dwp + DW'(1);
            if (w_pop)  r_drp <= r_drp + DW'(1);
            r_dcnt <= r_dcnt + (DW+1)'(w_push) - (DW+1)'(w_pop);
        end
    end

    rd_state_e          r_state, w_state_nxt;
    logic [BEAT_W-1:0]  r_left;
    logic               r_half;
    logic               w_issue, w_iss_sop, w_iss_eop, w_iss_half, w_o_take, w_s1_free;
    logic               r_s1_valid, r_s1_sop, r_s1_eop, r_s1_half;
    logic [LEN_W-1:0]   r_s1_len;
    logic               r_ovalid, r_ohalf, r_osop, r_oeop;
    logic [LEN_W-1:0]   r_oplen;
    logic [OUTPUT_WIDTH-1:0] r_odata;

    // Two-stage read pipeline: RAM read register (s1) then output register.
    assign w_o_take  = !r_ovalid || oready;
    assign w_s1_free = !r_s1_valid || w_o_take;

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) r_state <= ST_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_pop && !w_iss_eop)   w_state_nxt = ST_SEND;
            ST_SEND: if (w_issue && w_iss_eop)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_issue    = 1'b0;
        w_pop      = 1'b0;
        w_iss_sop  = 1'b0;
        w_iss_eop  = 1'b0;
        w_iss_half = 1'b0;
        case (r_state)
            ST_IDLE: if (!w_dempty && w_s1_free) begin
                w_issue    = 1'b1;
                w_pop      = 1'b1;
                w_iss_sop  = 1'b1;
                w_iss_eop  = (w_desc_rd.beats == BEAT_W'(1));
                w_iss_half = w_desc_rd.half && w_iss_eop;
            end
            ST_SEND: if (w_s1_free) begin
                w_issue    = 1'b1;
                w_iss_eop  = (r_left == BEAT_W'(1));
                w_iss_half = r_half && w_iss_eop;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            r_left     <= '0;
            r_half     <= 1'b0;
            r_rptr     <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sop   <= 1'b0;
            r_s1_eop   <= 1'b0;
            r_s1_half  <= 1'b0;
            r_s1_len   <= '0;
            r_ovalid   <= 1'b0;
            r_ohalf    <= 1'b0;
            r_osop     <= 1'b0;
            r_oeop     <= 1'b0;
            r_oplen    <= '0;
            r_odata    <= '0;
        end else begin
            if (w_pop) begin
                r_left   <= w_desc_rd.beats - BEAT_W'(1);
                r_half   <= w_desc_rd.half;
                r_s1_len <= w_desc_rd.len;
            end else if (w_issue) begin
                r_left <= r_left - BEAT_W'(1);
            end
            if (w_issue) begin
                r_rptr     <= r_rptr + AW'(1);
                r_s1_valid <= 1'b1;
                r_s1_sop   <= w_iss_sop;
                r_s1_eop   <= w_iss_eop;
                r_s1_half  <= w_iss_half;
            end else if (w_o_take) begin
                r_s1_valid <= 1'b0;
            end
            if (w_o_take) begin
                r_ovalid <= r_s1_valid;
                r_osop   <= r_s1_valid && r_s1_sop;
                r_oeop   <= r_s1_valid && r_s1_eop;
                r_ohalf  <= r_s1_valid && r_s1_half;
                if (r_s1_valid)             r_odata <= w_rdata;
                if (r_s1_valid && r_s1_sop) r_oplen <= r_s1_len;
            end
        end
    end

    pkt_buf_ram #(.DEPTH(BUF_DEPTH), .WIDTH(OUTPUT_WIDTH)) u_buf (
        .iclk    (iclk),
        .i_we    (w_we),
        .i_waddr (w_base),
        .i_wdata (w_wdata),
        .i_re    (w_issue),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign ovalid           = r_ovalid;
    assign ohalf_word_valid = r_ohalf;
    assign osop             = r_osop;
    assign oeop             = r_oeop;
    assign oplen            = r_oplen;
    assign odata            = r_odata;
    assign obad             = 1'b0;
    assign ocpu_interrupt   = r_irq;
endmodule

// File: tb/tb_pkt_translator.sv
// Self-checking bench for pkt_translator: packet table plus hand-written corner sequences.
module tb_pkt_translator;
  localparam int SB_W = 64 + 3 + 14;

  logic        iclk = 1'b0;
  logic        irst_n, ivalid, isop, ieop, ibad;
  logic [1:0]  iresidual;
  logic [31:0] idata;
  logic        ovalid, ohalf_word_valid, osop, oeop, obad, oready, ocpu_interrupt;
  logic [13:0] oplen;
  logic [63:0] odata;

  always #5 iclk = ~iclk;

  pkt_translator #(.INPUT_WIDTH(32), .OUTPUT_WIDTH(64), .BUF_DEPTH(2048), .DESC_DEPTH(16)) dut (
    .iclk(iclk), .irst_n(irst_n), .ivalid(ivalid), .isop(isop), .ieop(ieop),
    .iresidual(iresidual), .idata(idata), .ibad(ibad), .ovalid(ovalid),
    .ohalf_word_valid(ohalf_word_valid), .osop(osop), .oeop(oeop), .oplen(oplen),
    .odata(odata), .obad(obad), .oready(oready), .ocpu_interrupt(ocpu_interrupt)
  );

  // rdy_mode: 0 = always ready, 1 = random, 2 = stalled
  int   rdy_mode = 0;
  logic rnd_bit = 1'b1;
  always @(posedge iclk) begin
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end
  assign oready = (rdy_mode == 2) ? 1'b0 : (rdy_mode == 1) ? rnd_bit : 1'b1;

  logic [SB_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int irq_cnt = 0;
  int exp_irq = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: got condition expected absent", nm);
  endtask

  // Scoreboard monitor on the falling edge.
  logic [81:0] prev_out;
  logic        prev_stall = 1'b0;
  always @(negedge iclk) begin
    logic [SB_W-1:0] e;
    logic [81:0]     cur;
    cur = {ovalid, odata, osop, oeop, ohalf_word_valid, oplen};
    if (irst_n) begin
      if (ocpu_interrupt) irq_cnt++;
      if (prev_stall) check("stall_hold", cur, prev_out);
      if (ohalf_word_valid && !ovalid) fail("half_without_valid");
      if (ovalid && oready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data %h expected no beat", odata);
        end else begin
          e = exp_q.pop_front();
          check("beat", {odata, osop, oeop, ohalf_word_valid, (osop ? oplen : e[13:0])}, e);
          check("obad", obad, 1'b0);
        end
      end
      prev_stall = ovalid && !oready;
      prev_out   = cur;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic drive_word(input logic sop, input logic eop, input logic [1:0] res,
                            input logic [31:0] d, input logic bad);
    ivalid = 1'b1; isop = sop; ieop = eop; iresidual = res; idata = d; ibad = bad;
    @(posedge iclk);
    #1;
  endtask

  task automatic idle_inputs();
    ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ibad = 1'b0; iresidual = 2'd0;
  endtask

  // Drives one packet; queues its expected beats if keep, else expects a drop interrupt.
  task automatic send_pkt(input int nw, input int res, input int bad_idx, input int exp_len, input bit keep);
    logic [31:0] w[$];
    logic [1:0]  r2;
    logic [13:0] l14;
    logic [31:0] hi, lo;
    logic        sop, eop, half;
    int          nb;
    r2  = res[1:0];
    l14 = exp_len[13:0];
    for (int i = 0; i < nw; i++) w.push_back($urandom());
    for (int i = 0; i < nw; i++) drive_word(i == 0, i == nw - 1, r2, w[i], i == bad_idx);
    idle_inputs();
    if (keep && bad_idx < 0) begin
      nb = (nw + 1) / 2;
      for (int b = 0; b < nb; b++) begin
        hi   = w[2*b];
        lo   = (2*b + 1 < nw) ? w[2*b+1] : 32'h0;
        sop  = (b == 0);
        eop  = (b == nb - 1);
        half = eop && (nw % 2 == 1);
        exp_q.push_back({hi, lo, sop, eop, half, (sop ? l14 : 14'd0)});
      end
    end else begin
      exp_irq++;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 20000) begin
      @(negedge iclk);
      t++;
    end
    if (exp_q.size() > 0) fail("drain_timeout");
    repeat (6) @(posedge iclk);
    #1;
  endtask

  typedef struct {
    int nw;
    int res;
    int bad_idx;
    int exp_len;
  } vec_t;
  vec_t vecs[11];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int t;
    vecs[0]  = '{16, 0, -1, 64};
    vecs[1]  = '{17, 2, -1, 66};
    vecs[2]  = '{5, 0, 2, 0};
    vecs[3]  = '{16, 0, -1, 64};
    vecs[4]  = '{1, 1, -1, 1};
    vecs[5]  = '{1, 0, -1, 4};
    vecs[6]  = '{2, 3, -1, 7};
    vecs[7]  = '{3, 0, -1, 12};
    vecs[8]  = '{7, 1, 6, 0};
    vecs[9]  = '{8, 2, 0, 0};
    vecs[10] = '{4, 0, -1, 16};

    irst_n = 1'b0;
    idata  = '0;
    idle_inputs();
    repeat (3) @(negedge iclk);
    check("reset_outputs", {ovalid, ohalf_word_valid, osop, oeop, oplen, odata, obad, ocpu_interrupt}, '0);
    @(posedge iclk); #1;
    irst_n = 1'b1;
    @(posedge iclk); #1;

    // Latency: SOP beat in cycle N+3 after EOP, then 8 gap-free beats.
    send_pkt(16, 0, -1, 64, 1);
    @(negedge iclk);
    check("lat_n1_idle", ovalid, 1'b0);
    @(negedge iclk);
    check("lat_n2_idle", ovalid, 1'b0);
    @(negedge iclk);
    check("lat_n3_sop", {ovalid, osop}, 2'b11);
    cnt = 1;
    repeat (7) begin
      @(negedge iclk);
      cnt += int'(ovalid);
    end
    check("no_gap_beats", cnt, 8);
    wait_drain();

    for (int v = 0; v < 11; v++) begin
      send_pkt(vecs[v].nw, vecs[v].res, vecs[v].bad_idx, vecs[v].exp_len, 1);
      @(negedge iclk); #1;
      check("irq_vec", irq_cnt, exp_irq);
      @(posedge iclk); #1;
    end
    wait_drain();
    check("irq_table", irq_cnt, exp_irq);

    // Jumbo then short packet back-to-back with random backpressure.
    rdy_mode = 1;
    send_pkt(2304, 0, -1, 9216, 1);
    send_pkt(25, 0, -1, 100, 1);
    wait_drain();
    rdy_mode = 0;

    // isop inside an open packet drops the open one.
    for (int i = 0; i < 6; i++) drive_word(i == 0, 1'b0, 2'd0, $urandom(), 1'b0);
    send_pkt(10, 1, -1, 37, 1);
    exp_irq++;
    wait_drain();
    check("irq_isop_mid", irq_cnt, exp_irq);

    // Word with no open packet and no isop is ignored.
    drive_word(1'b0, 1'b1, 2'd0, $urandom(), 1'b0);
    idle_inputs();
    send_pkt(2, 2, -1, 6, 1);
    wait_drain();
    check("irq_ignored", irq_cnt, exp_irq);

    // Descriptor FIFO full: 16 queued plus 2 in the read pipeline, the rest dropped.
    rdy_mode = 2;
    for (int k = 0; k < 20; k++) send_pkt(1, k % 4, -1, (k % 4 == 0) ? 4 : k % 4, k < 18);
    repeat (4) @(posedge iclk); #1;
    check("irq_desc_full", irq_cnt, exp_irq);
    rdy_mode = 1;
    wait_drain();
    rdy_mode = 0;

    // Reset mid-packet while a beat is stalled on the output.
    rdy_mode = 2;
    send_pkt(16, 0, -1, 64, 1);
    t = 0;
    while (!ovalid && t < 50) begin
      @(negedge iclk);
      t++;
    end
    if (!ovalid) fail("wait_ovalid_timeout");
    @(posedge iclk); #1;
    for (int i = 0; i < 3; i++) drive_word(i == 0, 1'b0, 2'd0, $urandom(), 1'b0);
    irst_n = 1'b0;
    idle_inputs();
    exp_q.delete();
    @(negedge iclk);
    check("mid_reset_outputs", {ovalid, ohalf_word_valid, osop, oeop, oplen, odata, obad, ocpu_interrupt}, '0);
    @(posedge iclk); #1;
    irst_n   = 1'b1;
    rdy_mode = 0;
    @(posedge iclk); #1;
    send_pkt(16, 0, -1, 64, 1);
    wait_drain();
    check("irq_final", irq_cnt, exp_irq);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
